// File: rtl/layer_norm_matrix_unloader.sv
`default_nettype none
// ============================================================================
// Module   : layer_norm_matrix_unloader
// Purpose  : Consumer end of the matrix LayerNorm output. A matrix_done
//            pulse snapshots the whole flattened result bus into a local
//            buffer. The buffer is then streamed in row-major order as
//            ELEMS_PER_BEAT-element beats over a valid/ready handshake.
//            ready_for_matrix is low while a matrix drains. A matrix that
//            arrives while draining sets a sticky overrun flag.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            y_matrix_flat_in       - flattened matrix, element idx at
//                                     [idx*Y_WIDTH +: Y_WIDTH]
//            matrix_done            - capture strobe for y_matrix_flat_in
//            ready_for_matrix       - high when idle
//            out_data/out_valid/out_ready - beat stream, lane k = col0+k
//            out_row/out_beat       - position of the current beat
//            out_last_row/out_last  - end-of-row / end-of-matrix tags
//            unload_done            - pulse after the final handshake
//            overrun_err            - sticky early-matrix flag
//            stall_cycles           - valid && !ready cycle count
// Options  : LN_UNLOAD_STALL_COUNT_EN - builds the saturating stall counter;
//            when undefined, stall_cycles is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module layer_norm_matrix_unloader #(
   parameter int MATRIX_SIZE    = 64,
   parameter int Y_WIDTH        = 16,
   parameter int ELEMS_PER_BEAT = 4
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [MATRIX_SIZE*MATRIX_SIZE*Y_WIDTH-1:0]    y_matrix_flat_in,
   input  logic                                          matrix_done,
   output logic                                          ready_for_matrix,
   output logic [ELEMS_PER_BEAT*Y_WIDTH-1:0]             out_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [$clog2(MATRIX_SIZE)-1:0]                out_row,
   output logic [$clog2(MATRIX_SIZE/ELEMS_PER_BEAT)-1:0] out_beat,
   output logic                                          out_last_row,
   output logic                                          out_last,
   output logic                                          unload_done,
   output logic                                          overrun_err,
   output logic [31:0]                                   stall_cycles
);

   localparam int c_BEATS_PER_ROW = MATRIX_SIZE / ELEMS_PER_BEAT;
   localparam int c_ROW_W         = $clog2(MATRIX_SIZE);
   localparam int c_BEAT_W        = $clog2(c_BEATS_PER_ROW);
   localparam int c_FLAT_W        = c_ROW_W + c_BEAT_W;
   localparam int c_BEAT_BITS     = ELEMS_PER_BEAT * Y_WIDTH;
   localparam int c_BUS_BITS      = MATRIX_SIZE * MATRIX_SIZE * Y_WIDTH;

   localparam logic [c_ROW_W-1:0]  c_LAST_ROW  = c_ROW_W'(MATRIX_SIZE - 1);
   localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS_PER_ROW - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_ROW_W-1:0]    r_row;
   logic [c_ROW_W-1:0]    w_row_nxt;
   logic [c_BEAT_W-1:0]   r_beat;
   logic [c_BEAT_W-1:0]   w_beat_nxt;
   logic [c_BUS_BITS-1:0] r_buf;
   logic                  r_unload_done;
   logic                  r_overrun;
   logic                  w_capture;
   logic                  w_done_nxt;
   logic                  w_overrun_set;
   logic                  w_handshake;
   logic [c_FLAT_W-1:0]   w_flat_beat;

   assign out_valid        = (r_state == S_STREAM);
   assign ready_for_matrix = (r_state == S_IDLE);
   assign w_handshake      = out_valid && out_ready;
   assign out_last_row     = out_valid && (r_beat == c_LAST_BEAT);
   assign out_last         = out_last_row && (r_row == c_LAST_ROW);
   assign out_row          = r_row;
   assign out_beat         = r_beat;
   assign unload_done      = r_unload_done;
   assign overrun_err      = r_overrun;

   // Beats of one row are contiguous in the flat bus, so the beat's slice
   // starts at (row*beats_per_row + beat) whole beats.
   assign w_flat_beat = c_FLAT_W'(r_row) * c_FLAT_W'(c_BEATS_PER_ROW) + c_FLAT_W'(r_beat);
   assign out_data    = out_valid ? r_buf[w_flat_beat*c_BEAT_BITS +: c_BEAT_BITS] : '0;

   always_comb begin
      w_state_nxt   = r_state;
      w_row_nxt     = r_row;
      w_beat_nxt    = r_beat;
      w_capture     = 1'b0;
      w_done_nxt    = 1'b0;
      w_overrun_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (matrix_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_STREAM;
               w_row_nxt   = '0;
               w_beat_nxt  = '0;
            end
         end
         S_STREAM: begin
            if (w_handshake) begin
               if (r_beat == c_LAST_BEAT) begin
                  w_beat_nxt = '0;
                  w_row_nxt  = r_row + 1'b1;
               end else begin
                  w_beat_nxt = r_beat + 1'b1;
               end
            end
            if (w_handshake && out_last) begin
               w_done_nxt = 1'b1;
               w_row_nxt  = '0;
               w_beat_nxt = '0;
               // A new matrix landing on the final handshake is a legal
               // back-to-back transfer: stay in STREAM with the new data.
               if (matrix_done) begin
                  w_capture = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (matrix_done) begin
               w_overrun_set = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_row         <= '0;
         r_beat        <= '0;
         r_unload_done <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_row         <= w_row_nxt;
         r_beat        <= w_beat_nxt;
         r_unload_done <= w_done_nxt;
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Buffer contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_buf <= y_matrix_flat_in;
      end
   end

`ifdef LN_UNLOAD_STALL_COUNT_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
      end else if (w_capture) begin
         r_stall_cycles <= '0;
      end else if (out_valid && !out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
